// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the command stream, ALU operand/result bus and response stream of alu_cmd_sequencer.
// master is the sequencer side; slave is the command source / ALU / response consumer side.
interface alu_cmd_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic             cmd_use_acc;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_wr_acc;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;

  logic [WIDTH-1:0] acc;

  modport master (
    input  cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, cmd_wr_acc,
    input  alu_result, alu_carry, alu_zero,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero,
    output acc
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, cmd_wr_acc,
    output alu_result, alu_carry, alu_zero,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero,
    input  acc
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues commands to a combinational ALU, captures result/flags into an accumulator and response.
// Optional statistics counters (op_count, zero_count) are enabled by defining ALU_SEQ_STATS_EN.
module alu_cmd_sequencer #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.master bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]         op_count,
  output logic [15:0]         zero_count
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             wr_acc_q, wr_acc_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    wr_acc_d     = wr_acc_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    acc_d        = acc_q;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          // Accumulator operand is the value before this command executes.
          alu_a_d  = bus.cmd_use_acc ? acc_q : bus.cmd_a;
          alu_b_d  = bus.cmd_b;
          alu_op_d = bus.cmd_op;
          wr_acc_d = bus.cmd_wr_acc;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        rsp_result_d = bus.alu_result;
        rsp_carry_d  = bus.alu_carry;
        rsp_zero_d   = bus.alu_zero;
        if (wr_acc_q) begin
          acc_d = bus.alu_result;
        end
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      wr_acc_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      acc_q        <= ACC_INIT;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      wr_acc_q     <= wr_acc_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      acc_q        <= acc_d;
    end
  end

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.acc        = acc_q;

`ifdef ALU_SEQ_STATS_EN
  logic        rsp_hs;
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] zero_count_q, zero_count_d;

  assign rsp_hs = bus.rsp_valid && bus.rsp_ready;

  // Both counters saturate rather than wrap.
  always_comb begin
    op_count_d   = op_count_q;
    zero_count_d = zero_count_q;
    if (rsp_hs && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
    if (rsp_hs && rsp_zero_q && (zero_count_q != 16'hFFFF)) begin
      zero_count_d = zero_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q   <= '0;
      zero_count_q <= '0;
    end else begin
      op_count_q   <= op_count_d;
      zero_count_q <= zero_count_d;
    end
  end

  assign op_count   = op_count_q;
  assign zero_count = zero_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural 8-bit ALU model.
// Stats counters are checked when ALU_SEQ_STATS_EN is defined.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(8)) bus ();

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count;
  logic [15:0] zero_count;
`endif

  alu_cmd_sequencer #(
    .WIDTH   (8),
    .ACC_INIT(8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count  (op_count),
    .zero_count(zero_count)
`endif
  );

  // ALU model: carry is the 9th bit for ADD/SUB (borrow), shifted-out bit for shifts.
  logic [8:0] alu_full;
  always_comb begin
    alu_full = '0;
    case (bus.alu_opcode)
      3'd0: alu_full = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd1: alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'd2: alu_full = {1'b0, bus.alu_a & bus.alu_b};
      3'd3: alu_full = {1'b0, bus.alu_a | bus.alu_b};
      3'd4: alu_full = {1'b0, bus.alu_a ^ bus.alu_b};
      3'd5: alu_full = {1'b0, ~bus.alu_a};
      3'd6: alu_full = {bus.alu_a, 1'b0};
      3'd7: alu_full = {bus.alu_a[0], 1'b0, bus.alu_a[7:1]};
      default: alu_full = '0;
    endcase
  end
  assign bus.alu_result = alu_full[7:0];
  assign bus.alu_carry  = alu_full[8];
  assign bus.alu_zero   = (alu_full[7:0] == 8'h00);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one command with rsp_ready high; called just after a rising edge with the DUT idle.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic use_acc,
                         input logic [7:0] a, input logic [7:0] b, input logic wr,
                         input logic [7:0] exp_a, input logic [7:0] exp_res,
                         input logic exp_c, input logic exp_z, input logic [7:0] exp_acc);
    bus.cmd_op      = op;
    bus.cmd_use_acc = use_acc;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_wr_acc  = wr;
    bus.cmd_valid   = 1'b1;
    bus.rsp_ready   = 1'b1;
    check({tag, ".ready_idle"}, 16'(bus.cmd_ready), 16'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check({tag, ".issue_valid"}, 16'(bus.rsp_valid), 16'd0);
    check({tag, ".alu_a"}, 16'(bus.alu_a), 16'(exp_a));
    @(posedge clk); #1;
    check({tag, ".rsp_valid"}, 16'(bus.rsp_valid), 16'd1);
    check({tag, ".result"}, 16'(bus.rsp_result), 16'(exp_res));
    check({tag, ".carry"}, 16'(bus.rsp_carry), 16'(exp_c));
    check({tag, ".zero"}, 16'(bus.rsp_zero), 16'(exp_z));
    check({tag, ".acc"}, 16'(bus.acc), 16'(exp_acc));
    @(posedge clk); #1;
    check({tag, ".back_idle"}, 16'(bus.rsp_valid), 16'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_use_acc = 1'b0;
    bus.cmd_a       = '0;
    bus.cmd_b       = '0;
    bus.cmd_wr_acc  = 1'b0;
    bus.rsp_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst.cmd_ready", 16'(bus.cmd_ready), 16'd1);
    check("rst.rsp_valid", 16'(bus.rsp_valid), 16'd0);
    check("rst.acc", 16'(bus.acc), 16'h00);
    check("rst.alu_a", 16'(bus.alu_a), 16'h00);
    check("rst.alu_b", 16'(bus.alu_b), 16'h00);
    check("rst.alu_op", 16'(bus.alu_opcode), 16'h0);
    check("rst.rsp_result", 16'(bus.rsp_result), 16'h00);
    @(posedge clk); #1;

    run_cmd("add", 3'd0, 1'b0, 8'hF0, 8'h20, 1'b1, 8'hF0, 8'h10, 1'b1, 1'b0, 8'h10);
    run_cmd("sub_acc", 3'd1, 1'b1, 8'h77, 8'h10, 1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 8'h00);
    run_cmd("sub_imm", 3'd1, 1'b0, 8'h03, 8'h05, 1'b0, 8'h03, 8'hFE, 1'b1, 1'b0, 8'h00);
    check("sub_imm.alu_b_hold", 16'(bus.alu_b), 16'h05);
    check("sub_imm.alu_op_hold", 16'(bus.alu_opcode), 16'h1);

    run_cmd("chain0", 3'd0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 8'h01);
    run_cmd("chain1", 3'd0, 1'b1, 8'h00, 8'h01, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 8'h02);
    run_cmd("chain2", 3'd0, 1'b1, 8'h00, 8'h01, 1'b1, 8'h02, 8'h03, 1'b0, 1'b0, 8'h03);
    run_cmd("chain3", 3'd0, 1'b1, 8'h00, 8'h01, 1'b1, 8'h03, 8'h04, 1'b0, 1'b0, 8'h04);
    run_cmd("shl_acc", 3'd6, 1'b1, 8'h00, 8'h00, 1'b1, 8'h04, 8'h08, 1'b0, 1'b0, 8'h08);

    // Backpressure: XOR held in RESP while a competing command is offered.
    bus.cmd_op      = 3'd4;
    bus.cmd_use_acc = 1'b0;
    bus.cmd_a       = 8'hAA;
    bus.cmd_b       = 8'hFF;
    bus.cmd_wr_acc  = 1'b0;
    bus.cmd_valid   = 1'b1;
    bus.rsp_ready   = 1'b0;
    @(posedge clk); #1;
    bus.cmd_op      = 3'd0;
    bus.cmd_a       = 8'h11;
    bus.cmd_b       = 8'h22;
    bus.cmd_wr_acc  = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp.rsp_valid", 16'(bus.rsp_valid), 16'd1);
      check("bp.result", 16'(bus.rsp_result), 16'h55);
      check("bp.cmd_ready", 16'(bus.cmd_ready), 16'd0);
      @(posedge clk); #1;
    end
    check("bp.alu_op_held", 16'(bus.alu_opcode), 16'h4);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.after_hs_valid", 16'(bus.rsp_valid), 16'd0);
    check("bp.after_hs_ready", 16'(bus.cmd_ready), 16'd1);
    check("bp.after_hs_result", 16'(bus.rsp_result), 16'h55);
    check("bp.acc", 16'(bus.acc), 16'h08);
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;

`ifdef ALU_SEQ_STATS_EN
    check("stats.op_count", op_count, 16'd9);
    check("stats.zero_count", zero_count, 16'd1);
`endif

    // Reset during ISSUE discards the in-flight accumulate.
    bus.cmd_op      = 3'd0;
    bus.cmd_use_acc = 1'b1;
    bus.cmd_b       = 8'h01;
    bus.cmd_wr_acc  = 1'b1;
    bus.cmd_valid   = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("rsti.in_issue", 16'(bus.cmd_ready), 16'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rsti.cmd_ready", 16'(bus.cmd_ready), 16'd1);
    check("rsti.acc", 16'(bus.acc), 16'h00);
    check("rsti.alu_a", 16'(bus.alu_a), 16'h00);
`ifdef ALU_SEQ_STATS_EN
    check("rsti.op_count", op_count, 16'd0);
    check("rsti.zero_count", zero_count, 16'd0);
`endif
    repeat (3) begin
      @(posedge clk); #1;
      check("rsti.no_rsp", 16'(bus.rsp_valid), 16'd0);
    end

    run_cmd("post_rst", 3'd7, 1'b0, 8'h81, 8'h00, 1'b1, 8'h81, 8'h40, 1'b1, 1'b0, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
